// File: rtl/uart_frame_parser.sv
// Reassembles the 12-byte traffic-status frame from the UART RX byte stream.
// Optional inter-byte gap timeout: define UART_FRAME_PARSER_TIMEOUT_EN.
module uart_frame_parser #(
    parameter logic [7:0] HEADER         = 8'hAB,
    parameter int         FRAME_LEN      = 12,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [9:0] x_min,
    output logic [9:0] x_max,
    output logic [9:0] y_min,
    output logic [9:0] y_max,
    output logic [4:0] red_time,
    output logic [4:0] green_time,
    output logic       traffic_light,
    output logic       human_violation,
    output logic       car_violation,
    output logic       traffic_amount,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       busy
);

    typedef enum logic {HUNT, COLLECT} state_t;

    localparam logic [3:0] LAST = 4'(FRAME_LEN - 1);

    state_t     state_q;
    logic [3:0] idx_q;
    logic [4:0] sh_red_q, sh_green_q;
    logic [9:0] sh_xmin_q, sh_xmax_q, sh_ymin_q, sh_ymax_q;
    logic [9:0] x_min_q, x_max_q, y_min_q, y_max_q;
    logic [4:0] red_q, green_q;
    logic [3:0] flags_q;
    logic       fv_q, fe_q;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       byte_ok;

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    logic [GW-1:0] gap_q;
`endif

    // Reserved bits of the fixed-format fields must arrive as zero.
    always_comb begin
        byte_ok = 1'b1;
        case (idx_q)
            4'd1, 4'd2:             byte_ok = (rx_data[7:5] == 3'b0);
            4'd3, 4'd5, 4'd7, 4'd9: byte_ok = (rx_data[7:2] == 6'b0);
            LAST:                   byte_ok = (rx_data[3:0] == 4'b0);
            default:                byte_ok = 1'b1;
        endcase
    end

    assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            idx_q      <= '0;
            sh_red_q   <= '0;
            sh_green_q <= '0;
            sh_xmin_q  <= '0;
            sh_xmax_q  <= '0;
            sh_ymin_q  <= '0;
            sh_ymax_q  <= '0;
            x_min_q    <= '0;
            x_max_q    <= '0;
            y_min_q    <= '0;
            y_max_q    <= '0;
            red_q      <= '0;
            green_q    <= '0;
            flags_q    <= '0;
            fv_q       <= 1'b0;
            fe_q       <= 1'b0;
            err_cnt_q  <= '0;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
            gap_q      <= '0;
`endif
        end else begin
            fv_q <= 1'b0;
            fe_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (rx_valid && rx_data == HEADER) begin
                        state_q <= COLLECT;
                        idx_q   <= 4'd1;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
                        gap_q   <= '0;
`endif
                    end
                end
                COLLECT: begin
                    if (rx_valid) begin
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
                        gap_q <= '0;
`endif
                        if (!byte_ok) begin
                            fe_q      <= 1'b1;
                            err_cnt_q <= err_cnt_d;
                            state_q   <= HUNT;
                            idx_q     <= '0;
                        end else if (idx_q == LAST) begin
                            x_min_q <= sh_xmin_q;
                            x_max_q <= sh_xmax_q;
                            y_min_q <= sh_ymin_q;
                            y_max_q <= sh_ymax_q;
                            red_q   <= sh_red_q;
                            green_q <= sh_green_q;
                            flags_q <= rx_data[7:4];
                            fv_q    <= 1'b1;
                            state_q <= HUNT;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                            case (idx_q)
                                4'd1:  sh_red_q         <= rx_data[4:0];
                                4'd2:  sh_green_q       <= rx_data[4:0];
                                4'd3:  sh_xmin_q[9:8]   <= rx_data[1:0];
                                4'd4:  sh_xmin_q[7:0]   <= rx_data;
                                4'd5:  sh_xmax_q[9:8]   <= rx_data[1:0];
                                4'd6:  sh_xmax_q[7:0]   <= rx_data;
                                4'd7:  sh_ymin_q[9:8]   <= rx_data[1:0];
                                4'd8:  sh_ymin_q[7:0]   <= rx_data;
                                4'd9:  sh_ymax_q[9:8]   <= rx_data[1:0];
                                4'd10: sh_ymax_q[7:0]   <= rx_data;
                                default: begin
                                end
                            endcase
                        end
                    end
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
                    else if (gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
                        fe_q      <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                        state_q   <= HUNT;
                        idx_q     <= '0;
                        gap_q     <= '0;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
`endif
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign x_min           = x_min_q;
    assign x_max           = x_max_q;
    assign y_min           = y_min_q;
    assign y_max           = y_max_q;
    assign red_time        = red_q;
    assign green_time      = green_q;
    assign traffic_light   = flags_q[3];
    assign human_violation = flags_q[2];
    assign car_violation   = flags_q[1];
    assign traffic_amount  = flags_q[0];
    assign frame_valid     = fv_q;
    assign frame_err       = fe_q;
    assign err_count       = err_cnt_q;
    assign busy            = (state_q == COLLECT);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser.
// Timeout cases run when UART_FRAME_PARSER_TIMEOUT_EN is defined.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] x_min, x_max, y_min, y_max;
    logic [4:0] red_time, green_time;
    logic       traffic_light, human_violation, car_violation, traffic_amount;
    logic       frame_valid, frame_err, busy;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    uart_frame_parser #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .red_time(red_time), .green_time(green_time),
        .traffic_light(traffic_light), .human_violation(human_violation),
        .car_violation(car_violation), .traffic_amount(traffic_amount),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .err_count(err_count), .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    int fv_cnt = 0, fe_cnt = 0, both = 0, strobes = 0;
    int fv_at[$];

    always @(posedge clk) begin
        if (frame_valid) begin
            fv_cnt++;
            fv_at.push_back(strobes);
        end
        if (frame_err) fe_cnt++;
        if (frame_valid && frame_err) both++;
        if (rx_valid) strobes++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f [12], input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(f[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_fields(input string t, input logic [9:0] xmn,
                                 input logic [9:0] xmx, input logic [9:0] ymn,
                                 input logic [9:0] ymx, input logic [4:0] r,
                                 input logic [4:0] g, input logic [3:0] fl);
        check({t, "_xmin"}, x_min, xmn);
        check({t, "_xmax"}, x_max, xmx);
        check({t, "_ymin"}, y_min, ymn);
        check({t, "_ymax"}, y_max, ymx);
        check({t, "_red"}, red_time, r);
        check({t, "_green"}, green_time, g);
        check({t, "_flags"},
              {traffic_light, human_violation, car_violation, traffic_amount}, fl);
    endtask

    logic [7:0] fa [12];
    logic [7:0] fb [12];
    logic [7:0] fm [12];
    logic [7:0] fx [12];
    int n0, e0;

    initial begin
        fa = '{8'hAB, 8'h09, 8'h04, 8'h00, 8'h64, 8'h01,
               8'h2C, 8'h00, 8'h32, 8'h00, 8'hC8, 8'hA0};
        fb = '{8'hAB, 8'h1F, 8'h10, 8'h03, 8'hFF, 8'h02,
               8'h00, 8'h01, 8'h2B, 8'h03, 8'hE7, 8'h50};
        fm = fa;
        fm[4] = 8'hAB;
        fx = fa;
        fx[11] = 8'hA1;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(2);
        reset = 1'b0;

        check("rst_data", {x_min, x_max, y_min, y_max, red_time, green_time,
              traffic_light, human_violation, car_violation, traffic_amount}, 0);
        check("rst_ctrl", {frame_valid, frame_err, busy, err_count}, 0);

        // leading garbage, then frame A
        send(8'h55);
        send(8'h12);
        check("garbage_busy", busy, 0);
        send(fa[0]);
        check("hdr_busy", busy, 1);
        send_frame(fa, 1, 11);
        check("a_latency", frame_valid, 1);
        check("a_busy_done", busy, 0);
        idle(2);
        check("a_pulse_len", frame_valid, 0);
        check("a_fv_cnt", fv_cnt, 1);
        check("a_no_err", fe_cnt, 0);
        expect_fields("a", 10'd100, 10'd300, 10'd50, 10'd200, 5'd9, 5'd4, 4'b1010);

        // bad coordinate high byte at index 3
        send_frame(fa, 0, 2);
        send(8'hFF);
        check("coord_err_pulse", frame_err, 1);
        check("coord_err_fv", frame_valid, 0);
        check("coord_err_cnt", err_count, 1);
        check("coord_err_busy", busy, 0);
        idle(1);
        check("coord_err_len", frame_err, 0);
        expect_fields("hold", 10'd100, 10'd300, 10'd50, 10'd200, 5'd9, 5'd4, 4'b1010);

        // header value as bad green byte: not a resync point
        n0 = fv_cnt;
        send(8'hAB);
        send(8'h09);
        send(8'hAB);
        check("tmr_err_pulse", frame_err, 1);
        send_frame(fa, 2, 11);
        idle(2);
        check("tmr_err_cnt", err_count, 2);
        check("tmr_no_resync", fv_cnt, n0);
        check("tmr_busy", busy, 0);

        // reserved flag bit set in final byte
        send_frame(fx, 0, 11);
        check("flag_err_pulse", frame_err, 1);
        check("flag_err_fv", frame_valid, 0);
        check("flag_err_cnt", err_count, 3);

        // header value as ordinary data mid-frame
        send_frame(fm, 0, 11);
        check("mid_hdr_fv", frame_valid, 1);
        expect_fields("mid", 10'd171, 10'd300, 10'd50, 10'd200, 5'd9, 5'd4, 4'b1010);

        // back-to-back frames, zero idle cycles
        idle(1);
        n0 = fv_at.size();
        e0 = fe_cnt;
        send_frame(fa, 0, 11);
        send_frame(fb, 0, 11);
        check("b2b_fv2", frame_valid, 1);
        idle(2);
        check("b2b_pulses", fv_at.size() - n0, 2);
        check("b2b_spacing", fv_at[n0 + 1] - fv_at[n0], 12);
        check("b2b_no_err", fe_cnt - e0, 0);
        expect_fields("b", 10'd1023, 10'd512, 10'd299, 10'd999, 5'd31, 5'd16, 4'b0101);

        // reset in the middle of a frame
        send_frame(fa, 0, 5);
        reset = 1'b1;
        #1;
        check("mrst_data", {x_min, x_max, y_min, y_max, red_time, green_time,
              traffic_light, human_violation, car_violation, traffic_amount}, 0);
        check("mrst_ctrl", {frame_valid, frame_err, busy, err_count}, 0);
        @(negedge clk);
        reset = 1'b0;
        send_frame(fa, 0, 11);
        check("mrst_fv", frame_valid, 1);
        expect_fields("mrst", 10'd100, 10'd300, 10'd50, 10'd200, 5'd9, 5'd4, 4'b1010);

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        idle(1);
        e0 = fe_cnt;
        send_frame(fb, 0, 4);
        idle(60);
        check("tmo_err", fe_cnt - e0, 1);
        check("tmo_cnt", err_count, 1);
        check("tmo_busy", busy, 0);
        expect_fields("tmo", 10'd100, 10'd300, 10'd50, 10'd200, 5'd9, 5'd4, 4'b1010);

        e0 = fe_cnt;
        send_frame(fb, 0, 4);
        idle(49);
        send_frame(fb, 5, 11);
        check("edge_fv", frame_valid, 1);
        idle(1);
        check("edge_no_err", fe_cnt - e0, 0);
        check("edge_cnt", err_count, 1);
        expect_fields("edge", 10'd1023, 10'd512, 10'd299, 10'd999, 5'd31, 5'd16, 4'b0101);
`endif

        idle(2);
        check("no_overlap", both, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Receive-side stage that consumes the byte stream from the UART RX path and reassembles the 12-byte traffic-status frame.
- Frame byte order: 0xAB header; red time; green time; x_min hi/lo; x_max hi/lo; y_min hi/lo; y_max hi/lo; flags.
- Outputs the decoded bounding box, light timers and status flags, updated atomically once per good frame.
- Feeds the VGA overlay/display logic on the receiving board.

Parameters:
- HEADER, 8'hAB, frame start byte.
- FRAME_LEN, 12, total bytes per frame including header.
- TIMEOUT_CYCLES, 1_000_000, maximum idle clk cycles between bytes inside a frame. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one per received byte.
- x_min  out  10  decoded box left.
- x_max  out  10  decoded box right.
- y_min  out  10  decoded box top.
- y_max  out  10  decoded box bottom.
- red_time  out  5  red remaining, as transmitted.
- green_time  out  5  green remaining, as transmitted.
- traffic_light  out  1  1=green, 0=red.
- human_violation  out  1  pedestrian violation flag.
- car_violation  out  1  vehicle violation flag.
- traffic_amount  out  1  0=low, 1=high.
- frame_valid  out  1  one-cycle pulse when a good frame commits.
- frame_err  out  1  one-cycle pulse when a frame is discarded.
- err_count  out  8  saturating count of discarded frames.
- busy  out  1  high while in COLLECT.

Behaviour:
- Reset: state=HUNT, byte index=0, all data outputs 0, frame_valid=0, frame_err=0, err_count=0, busy=0.
- HUNT:
  - Non-header bytes are ignored silently; they do not raise frame_err.
  - rx_valid with rx_data==HEADER -> COLLECT, index=1.
- COLLECT:
  - Each rx_valid stores rx_data into shadow byte[index] and increments index.
  - Shadow registers are internal; outputs are not touched until commit.
- Format checks, applied as each byte arrives:
  - Timer bytes (1, 2): bits[7:5] must be 0.
  - Coordinate high bytes (3, 5, 7, 9): bits[7:2] must be 0.
  - Flags byte (11): bits[3:0] must be 0.
  - On any violation: discard the frame, frame_err pulse next cycle, err_count+1 (saturates at 255), return to HUNT.
  - The offending byte is not re-examined as a header.
- A HEADER value arriving mid-frame is treated as data; there is no mid-frame resync.
- Commit:
  - When byte index FRAME_LEN-1 arrives and passes its check, all outputs update on the next clk edge.
  - frame_valid pulses that same cycle, and state returns to HUNT.
  - Latency: 1 cycle from the last byte's rx_valid to frame_valid.
- Field mapping:
  - x_min = {b3[1:0], b4}; x_max = {b5[1:0], b6}; y_min = {b7[1:0], b8}; y_max = {b9[1:0], b10}.
  - red_time = b1[4:0]; green_time = b2[4:0].
  - traffic_light = b11[7]; human_violation = b11[6]; car_violation = b11[5]; traffic_amount = b11[4].
- Outputs hold their last committed values across errors, timeouts and HUNT.
- frame_valid and frame_err are never high in the same cycle.
- Back-to-back frames: a header on the cycle after the commit is accepted. No dead cycles are required.
- busy = (state==COLLECT).

Optional Feature:
- Macro: UART_FRAME_PARSER_TIMEOUT_EN.
- Defined:
  - A gap counter clears on every rx_valid while in COLLECT and increments every other COLLECT cycle.
  - When the counter reaches TIMEOUT_CYCLES: frame_err pulse, err_count+1, return to HUNT, outputs unchanged.
  - If rx_valid arrives in the same cycle the counter would expire, the byte wins: it is accepted and the counter clears.
- Undefined: no gap counter; COLLECT waits indefinitely.

Test Plan:
- Send AB 09 04 00 64 01 2C 00 32 00 C8 A0 -> frame_valid one cycle after the last byte.
  - x_min=100, x_max=300, y_min=50, y_max=200.
  - red_time=9, green_time=4.
  - traffic_light=1, human_violation=0, car_violation=1, traffic_amount=0.
- Send 55 12 AB then a valid 11-byte body -> leading garbage ignored, frame_err never pulses, one frame_valid.
- Send a good frame, then AB 09 04 FF ... -> frame_err pulse at byte 3, err_count=1, outputs still hold the first frame's values.
- Send two good frames with zero idle cycles between them -> two frame_valid pulses exactly 12 rx_valid strobes apart, second frame's values present after the second pulse.
- Assert reset after the 6th byte of a frame, then send a full frame -> after reset all outputs=0 and err_count=0; the new frame decodes correctly.
- With UART_FRAME_PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=50:
  - Stall 60 cycles after byte 5 -> frame_err and return to HUNT.
  - Stall exactly 50 cycles with rx_valid on the expiry cycle -> byte accepted, no error.
